// File: rtl/inv_pipe_if.sv
// Mask-configuration handshake between a configuring master and inv_pipe.
interface inv_pipe_if #(
  parameter int WIDTH = 8
);
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_data;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/inv_pipe.sv
// Per-channel pass/invert/mask/hold conditioning followed by a fixed-latency
// register pipeline, with a fill flag and a saturating output-change counter.
module inv_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       mode,
  inv_pipe_if.slave        cfg,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam int                FILL_W    = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [WIDTH-1:0]  stage_r [DEPTH];
  logic [WIDTH-1:0]  mask_r;
  logic              cfg_ready_r;
  logic [FILL_W-1:0] fill_r;
  logic              dout_valid_r;
  logic [CNT_W-1:0]  edge_cnt_r;

  logic [WIDTH-1:0]  stage0_next_s;
  logic [WIDTH-1:0]  dout_next_s;
  logic              accept_s;

  // Stage-0 conditioning and mask-load acceptance
  always_comb begin
    stage0_next_s = stage_r[0];
    accept_s      = cfg.cfg_valid & cfg_ready_r;
    case (mode)
      2'b00:   stage0_next_s = din;
      2'b01:   stage0_next_s = ~din;
      2'b10:   stage0_next_s = din ^ mask_r;
      2'b11:   stage0_next_s = stage_r[0];
      default: stage0_next_s = stage_r[0];
    endcase
  end

  // The value dout will take on the coming edge, used by the change counter
  generate
    if (DEPTH == 1) begin : g_next_d1
      assign dout_next_s = stage0_next_s;
    end else begin : g_next_dn
      assign dout_next_s = stage_r[DEPTH-2];
    end
  endgenerate

  // Data pipeline: stage 0 conditioned, later stages shift unconditionally
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_r[0] <= stage0_next_s;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  // Mask register with one-cycle busy after every accepted load
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_r      <= {WIDTH{1'b0}};
      cfg_ready_r <= 1'b1;
    end else begin
      if (accept_s) begin
        mask_r <= cfg.cfg_data;
      end else begin
        mask_r <= mask_r;
      end
      cfg_ready_r <= ~accept_s;
    end
  end

  // Saturating fill counter; valid is registered so it rises on edge DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_r       <= {FILL_W{1'b0}};
      dout_valid_r <= 1'b0;
    end else begin
      if (fill_r != FILL_MAX) begin
        fill_r <= fill_r + FILL_W'(1);
      end else begin
        fill_r <= fill_r;
      end
      dout_valid_r <= (fill_r >= FILL_LAST);
    end
  end

  // Output-change counter, gated by an already-valid output; clear wins
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      edge_cnt_r <= {CNT_W{1'b0}};
    end else if (dout_valid_r && (dout_next_s != stage_r[DEPTH-1]) &&
                 (edge_cnt_r != CNT_MAX)) begin
      edge_cnt_r <= edge_cnt_r + CNT_W'(1);
    end else begin
      edge_cnt_r <= edge_cnt_r;
    end
  end

  assign dout          = stage_r[DEPTH-1];
  assign dout_valid    = dout_valid_r;
  assign edge_cnt      = edge_cnt_r;
  assign cfg.cfg_ready = cfg_ready_r;

endmodule

// File: tb/tb_inv_pipe.sv
// Directed and random checks of inv_pipe against a queue-based reference model.
module tb_inv_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic [1:0]       mode;
  logic             cnt_clr;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [CNT_W-1:0] edge_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of conditioned values in flight, newest at front
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_mask;
  bit               m_ready;
  int               m_edges;
  int               m_cnt;

  always #5 clk = ~clk;

  inv_pipe_if #(.WIDTH(WIDTH)) cfg_bus ();

  inv_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .mode       (mode),
    .cfg        (cfg_bus.slave),
    .cnt_clr    (cnt_clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .edge_cnt   (edge_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = {};
    for (int i = 0; i < DEPTH; i++) m_q.push_front('0);
    m_mask  = '0;
    m_ready = 1'b1;
    m_edges = 0;
    m_cnt   = 0;
  endtask

  task automatic step(input logic r, input logic [WIDTH-1:0] d, input logic [1:0] md,
                      input logic cv, input logic [WIDTH-1:0] cd, input logic cc);
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] old_out;
    bit               was_valid;
    rst = r; din = d; mode = md; cnt_clr = cc;
    cfg_bus.cfg_valid = cv; cfg_bus.cfg_data = cd;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      old_out   = m_q[DEPTH-1];
      was_valid = (m_edges >= DEPTH);
      case (md)
        2'b00:   f = d;
        2'b01:   f = ~d;
        2'b10:   f = d ^ m_mask;
        default: f = m_q[0];
      endcase
      if (cv && m_ready) begin
        m_mask  = cd;
        m_ready = 1'b0;
      end else begin
        m_ready = 1'b1;
      end
      m_q.push_front(f);
      void'(m_q.pop_back());
      if (m_edges < DEPTH) m_edges++;
      if (cc) m_cnt = 0;
      else if (was_valid && (m_q[DEPTH-1] != old_out) && (m_cnt < CNT_MAX)) m_cnt++;
    end
    #1;
    chk("model_dout", 32'(dout), 32'(m_q[DEPTH-1]));
    chk("model_valid", 32'(dout_valid), 32'(m_edges >= DEPTH));
    chk("model_cnt", 32'(edge_cnt), 32'(m_cnt));
    chk("model_ready", 32'(cfg_bus.cfg_ready), 32'(m_ready));
  endtask

  initial begin
    int toggle_cnt[6];
    toggle_cnt = '{0, 1, 2, 3, 3, 3};
    model_reset();

    // reset state
    step(1'b1, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    chk("rst_cnt", 32'(edge_cnt), 32'h0);
    chk("rst_ready", 32'(cfg_bus.cfg_ready), 32'h1);

    // latency after reset
    step(1'b0, 8'hA5, 2'b00, 1'b0, 8'h00, 1'b0);
    chk("lat_e1_dout", 32'(dout), 32'h0);
    chk("lat_e1_valid", 32'(dout_valid), 32'h0);
    step(1'b0, 8'hA5, 2'b00, 1'b0, 8'h00, 1'b0);
    chk("lat_e2_dout", 32'(dout), 32'hA5);
    chk("lat_e2_valid", 32'(dout_valid), 32'h1);

    // modes
    step(1'b0, 8'h0F, 2'b00, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h0F, 2'b00, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h0F, 2'b01, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h0F, 2'b01, 1'b0, 8'h00, 1'b0);
    chk("mode_inv", 32'(dout), 32'hF0);
    step(1'b0, 8'h0F, 2'b01, 1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h0F, 2'b10, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h0F, 2'b10, 1'b0, 8'h00, 1'b0);
    chk("mode_mask", 32'(dout), 32'h33);
    for (int i = 0; i < 3; i++) step(1'b0, 8'hFF, 2'b11, 1'b0, 8'h00, 1'b0);
    chk("mode_hold", 32'(dout), 32'h33);

    // handshake: second request while busy is dropped, then re-accepted
    step(1'b0, 8'h00, 2'b10, 1'b1, 8'h11, 1'b0);
    chk("hs_busy", 32'(cfg_bus.cfg_ready), 32'h0);
    step(1'b0, 8'h00, 2'b10, 1'b1, 8'h22, 1'b0);
    chk("hs_ready_again", 32'(cfg_bus.cfg_ready), 32'h1);
    chk("hs_old_mask_on_load", 32'(dout), 32'h3C);
    step(1'b0, 8'h00, 2'b10, 1'b1, 8'h22, 1'b0);
    chk("hs_second_busy", 32'(cfg_bus.cfg_ready), 32'h0);
    chk("hs_first_mask", 32'(dout), 32'h11);
    step(1'b0, 8'h00, 2'b10, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 2'b10, 1'b0, 8'h00, 1'b0);
    chk("hs_second_mask", 32'(dout), 32'h22);

    // counter saturation and clear priority
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b1);
    chk("cnt_cleared", 32'(edge_cnt), 32'h0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, (i % 2 == 0) ? 8'hFF : 8'h00, 2'b00, 1'b0, 8'h00, 1'b0);
      chk("cnt_toggle", 32'(edge_cnt), 32'(toggle_cnt[i]));
    end
    step(1'b0, 8'hFF, 2'b00, 1'b0, 8'h00, 1'b1);
    chk("cnt_clr_prio", 32'(edge_cnt), 32'h0);

    // reset mid-stream with a mask loaded and data in flight
    step(1'b0, 8'hA5, 2'b10, 1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'hC3, 2'b00, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h77, 2'b01, 1'b1, 8'h99, 1'b0);
    chk("mid_rst_dout", 32'(dout), 32'h0);
    chk("mid_rst_valid", 32'(dout_valid), 32'h0);
    chk("mid_rst_cnt", 32'(edge_cnt), 32'h0);
    chk("mid_rst_ready", 32'(cfg_bus.cfg_ready), 32'h1);
    step(1'b0, 8'h5A, 2'b10, 1'b0, 8'h00, 1'b0);
    chk("mid_rst_e1_valid", 32'(dout_valid), 32'h0);
    step(1'b0, 8'h5A, 2'b10, 1'b0, 8'h00, 1'b0);
    chk("mid_rst_mask_zero", 32'(dout), 32'h5A);
    chk("mid_rst_e2_valid", 32'(dout_valid), 32'h1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
           WIDTH'($urandom), 2'($urandom), 1'($urandom), WIDTH'($urandom),
           ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
